// File: rtl/pong_display_ctrl.sv
// Frame-synchronised Pong game-flow sequencer: tracks phase and scores and
// drives the per-layer display enables, ball motion gate and blink effects.
module pong_display_ctrl #(
    parameter int unsigned SERVE_FRAMES = 120,
    parameter int unsigned POINT_FRAMES = 60,
    parameter int unsigned BLINK_HALF   = 15,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       miss1,
    input  logic       miss2,
    output logic       pad1_en,
    output logic       pad2_en,
    output logic       ball_en,
    output logic       text_en,
    output logic       ball_run,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam int unsigned FMAX   = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int unsigned FCNT_W = (FMAX > 1) ? $clog2(FMAX) : 1;
    localparam int unsigned BCNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [FCNT_W-1:0] SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
    localparam logic [FCNT_W-1:0] POINT_LAST = FCNT_W'(POINT_FRAMES - 1);
    localparam logic [BCNT_W-1:0] BLINK_LAST = BCNT_W'(BLINK_HALF - 1);
    localparam logic [3:0]        WIN        = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_nxt;
    logic                start_q;
    logic                start_rise;
    logic                scorer_q;     // 0: player 1 scored last, 1: player 2
    logic                scorer_nxt;
    logic [FCNT_W-1:0]   fcnt_q;
    logic [FCNT_W-1:0]   fcnt_nxt;
    logic [BCNT_W-1:0]   bcnt_q;
    logic [BCNT_W-1:0]   bcnt_nxt;
    logic                phase_q;
    logic                phase_nxt;
    logic                entry;
    logic [3:0]          score1_nxt;
    logic [3:0]          score2_nxt;
    logic [1:0]          winner_nxt;
    logic                pad1_nxt;
    logic                pad2_nxt;
    logic                ball_nxt;
    logic                text_nxt;
    logic                run_nxt;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN) ? WIN : 4'(s + 4'd1);
    endfunction

    assign start_rise = start_btn & ~start_q;
    assign state      = state_q;

    // Next state, score bookkeeping, frame/blink counters and enable decode
    always_comb begin
        state_nxt  = state_q;
        score1_nxt = score1;
        score2_nxt = score2;
        winner_nxt = winner;
        scorer_nxt = scorer_q;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_nxt  = S_SERVE;
                    score1_nxt = 4'd0;
                    score2_nxt = 4'd0;
                    winner_nxt = 2'b00;
                end
            end
            S_SERVE: begin
                if (frame_tick && (fcnt_q == SERVE_LAST)) begin
                    state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (miss1 && miss2) begin
                    state_nxt = S_SERVE;
                end else if (miss1) begin
                    score2_nxt = sat_inc(score2);
                    scorer_nxt = 1'b1;
                    state_nxt  = S_POINT;
                end else if (miss2) begin
                    score1_nxt = sat_inc(score1);
                    scorer_nxt = 1'b0;
                    state_nxt  = S_POINT;
                end
            end
            S_POINT: begin
                if (frame_tick && (fcnt_q == POINT_LAST)) begin
                    if ((scorer_q ? score2 : score1) == WIN) begin
                        state_nxt  = S_OVER;
                        winner_nxt = scorer_q ? 2'b10 : 2'b01;
                    end else begin
                        state_nxt = S_SERVE;
                    end
                end
            end
            S_OVER: begin
                if (start_rise) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        entry = (state_nxt != state_q);

        // A tick coinciding with a state change is absorbed by the entry clear
        fcnt_nxt  = fcnt_q;
        bcnt_nxt  = bcnt_q;
        phase_nxt = phase_q;
        if (entry) begin
            fcnt_nxt  = '0;
            bcnt_nxt  = '0;
            phase_nxt = 1'b1;
        end else if (frame_tick) begin
            fcnt_nxt = FCNT_W'(fcnt_q + 1'b1);
            if (bcnt_q == BLINK_LAST) begin
                bcnt_nxt  = '0;
                phase_nxt = ~phase_q;
            end else begin
                bcnt_nxt = BCNT_W'(bcnt_q + 1'b1);
            end
        end

        pad1_nxt = 1'b1;
        pad2_nxt = 1'b1;
        ball_nxt = 1'b0;
        text_nxt = 1'b0;
        run_nxt  = 1'b0;
        case (state_nxt)
            S_IDLE:  text_nxt = 1'b1;
            S_SERVE: ball_nxt = phase_nxt;
            S_PLAY: begin
                ball_nxt = 1'b1;
                run_nxt  = 1'b1;
            end
            S_POINT: begin
                if (scorer_nxt) pad2_nxt = phase_nxt;
                else            pad1_nxt = phase_nxt;
            end
            S_OVER: begin
                text_nxt = 1'b1;
                if (winner_nxt == 2'b10)      pad2_nxt = phase_nxt;
                else if (winner_nxt == 2'b01) pad1_nxt = phase_nxt;
            end
            default: text_nxt = 1'b1;
        endcase
    end

    // All state and outputs registered; enables track the new state on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b1;
            scorer_q <= 1'b0;
            fcnt_q   <= '0;
            bcnt_q   <= '0;
            phase_q  <= 1'b1;
            score1   <= 4'd0;
            score2   <= 4'd0;
            winner   <= 2'b00;
            pad1_en  <= 1'b1;
            pad2_en  <= 1'b1;
            text_en  <= 1'b1;
            ball_en  <= 1'b0;
            ball_run <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            start_q  <= start_btn;
            scorer_q <= scorer_nxt;
            fcnt_q   <= fcnt_nxt;
            bcnt_q   <= bcnt_nxt;
            phase_q  <= phase_nxt;
            score1   <= score1_nxt;
            score2   <= score2_nxt;
            winner   <= winner_nxt;
            pad1_en  <= pad1_nxt;
            pad2_en  <= pad2_nxt;
            text_en  <= text_nxt;
            ball_en  <= ball_nxt;
            ball_run <= run_nxt;
        end
    end

endmodule

// File: tb/tb_pong_display_ctrl.sv
// Directed bench for pong_display_ctrl with short timing parameters.
module tb_pong_display_ctrl;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start_btn;
    logic       miss1;
    logic       miss2;
    logic       pad1_en;
    logic       pad2_en;
    logic       ball_en;
    logic       text_en;
    logic       ball_run;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] winner;
    logic [2:0] state;

    int vectors;
    int miscompares;

    // Observed bundles: {state, text, ball, run, pad1, pad2} and {score1, score2, winner}
    logic [7:0] o_en;
    logic [9:0] o_sc;

    pong_display_ctrl #(
        .SERVE_FRAMES(4),
        .POINT_FRAMES(2),
        .BLINK_HALF  (1),
        .WIN_SCORE   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .start_btn (start_btn),
        .miss1     (miss1),
        .miss2     (miss2),
        .pad1_en   (pad1_en),
        .pad2_en   (pad2_en),
        .ball_en   (ball_en),
        .text_en   (text_en),
        .ball_run  (ball_run),
        .score1    (score1),
        .score2    (score2),
        .winner    (winner),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign o_en = {state, text_en, ball_en, ball_run, pad1_en, pad2_en};
    assign o_sc = {score1, score2, winner};

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Nine quiet clocks, then a frame_tick pulse; returns just after the tick edge
    task automatic frame();
        step(9);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        start_btn = 1'b1;
        reset     = 1'b1;
        step(2);
        vectors++;
        if (o_en !== 8'b000_1_0_0_1_1) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected %b", o_en, 8'b000_1_0_0_1_1);
        end
        vectors++;
        if (o_sc !== 10'b0000_0000_00) begin
            miscompares++;
            $display("FAIL reset_scores: got %b expected %b", o_sc, 10'b0000_0000_00);
        end
        reset = 1'b0;
        step(3);
        vectors++;
        if (o_en !== 8'b000_1_0_0_1_1) begin
            miscompares++;
            $display("FAIL held_start_ignored: got %b expected %b", o_en, 8'b000_1_0_0_1_1);
        end
        start_btn = 1'b0;
        step(1);
        start_btn = 1'b1;
        step(1);
        vectors++;
        if (o_en !== 8'b001_0_1_0_1_1) begin
            miscompares++;
            $display("FAIL start_to_serve: got %b expected %b", o_en, 8'b001_0_1_0_1_1);
        end
        start_btn = 1'b0;
    endtask

    task automatic test_serve();
        logic [7:0] exp_en [4];
        exp_en[0] = 8'b001_0_0_0_1_1;
        exp_en[1] = 8'b001_0_1_0_1_1;
        exp_en[2] = 8'b001_0_0_0_1_1;
        exp_en[3] = 8'b010_0_1_1_1_1;
        for (int i = 0; i < 4; i++) begin
            frame();
            vectors++;
            if (o_en !== exp_en[i]) begin
                miscompares++;
                $display("FAIL serve_tick%0d: got %b expected %b", i + 1, o_en, exp_en[i]);
            end
        end
    endtask

    task automatic test_scoring();
        step(2);
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        vectors++;
        if (o_en !== 8'b010_0_1_1_1_1) begin
            miscompares++;
            $display("FAIL start_in_play: got %b expected %b", o_en, 8'b010_0_1_1_1_1);
        end
        miss2 = 1'b1;
        step(1);
        miss2 = 1'b0;
        vectors++;
        if (o_en !== 8'b011_0_0_0_1_1) begin
            miscompares++;
            $display("FAIL miss2_point: got %b expected %b", o_en, 8'b011_0_0_0_1_1);
        end
        vectors++;
        if (o_sc !== 10'b0001_0000_00) begin
            miscompares++;
            $display("FAIL miss2_score: got %b expected %b", o_sc, 10'b0001_0000_00);
        end
        frame();
        vectors++;
        if (o_en !== 8'b011_0_0_0_0_1) begin
            miscompares++;
            $display("FAIL point_pad1_blink: got %b expected %b", o_en, 8'b011_0_0_0_0_1);
        end
        frame();
        vectors++;
        if (o_en !== 8'b001_0_1_0_1_1) begin
            miscompares++;
            $display("FAIL point_to_serve: got %b expected %b", o_en, 8'b001_0_1_0_1_1);
        end
    endtask

    task automatic test_double_miss();
        repeat (4) frame();
        vectors++;
        if (o_en !== 8'b010_0_1_1_1_1) begin
            miscompares++;
            $display("FAIL reserve_play: got %b expected %b", o_en, 8'b010_0_1_1_1_1);
        end
        miss1 = 1'b1;
        miss2 = 1'b1;
        step(1);
        miss1 = 1'b0;
        miss2 = 1'b0;
        vectors++;
        if (o_en !== 8'b001_0_1_0_1_1) begin
            miscompares++;
            $display("FAIL double_miss_state: got %b expected %b", o_en, 8'b001_0_1_0_1_1);
        end
        vectors++;
        if (o_sc !== 10'b0001_0000_00) begin
            miscompares++;
            $display("FAIL double_miss_score: got %b expected %b", o_sc, 10'b0001_0000_00);
        end
        miss1 = 1'b1;
        step(1);
        miss1 = 1'b0;
        miss2 = 1'b1;
        step(1);
        miss2 = 1'b0;
        step(1);
        vectors++;
        if ({o_en, o_sc} !== {8'b001_0_1_0_1_1, 10'b0001_0000_00}) begin
            miscompares++;
            $display("FAIL serve_miss_ignored: got %b expected %b", {o_en, o_sc},
                     {8'b001_0_1_0_1_1, 10'b0001_0000_00});
        end
    endtask

    task automatic test_game_over();
        repeat (4) frame();
        miss1 = 1'b1;
        step(1);
        miss1 = 1'b0;
        vectors++;
        if ({o_en, o_sc} !== {8'b011_0_0_0_1_1, 10'b0001_0001_00}) begin
            miscompares++;
            $display("FAIL first_miss1: got %b expected %b", {o_en, o_sc},
                     {8'b011_0_0_0_1_1, 10'b0001_0001_00});
        end
        frame();
        vectors++;
        if (o_en !== 8'b011_0_0_0_1_0) begin
            miscompares++;
            $display("FAIL point_pad2_blink: got %b expected %b", o_en, 8'b011_0_0_0_1_0);
        end
        frame();
        repeat (4) frame();
        // Miss coincides with a frame tick: that tick must not count in POINT
        miss1      = 1'b1;
        frame_tick = 1'b1;
        step(1);
        miss1      = 1'b0;
        frame_tick = 1'b0;
        vectors++;
        if ({o_en, o_sc} !== {8'b011_0_0_0_1_1, 10'b0001_0010_00}) begin
            miscompares++;
            $display("FAIL second_miss1: got %b expected %b", {o_en, o_sc},
                     {8'b011_0_0_0_1_1, 10'b0001_0010_00});
        end
        frame();
        vectors++;
        if (o_en !== 8'b011_0_0_0_1_0) begin
            miscompares++;
            $display("FAIL tick_not_counted: got %b expected %b", o_en, 8'b011_0_0_0_1_0);
        end
        frame();
        vectors++;
        if ({o_en, o_sc} !== {8'b100_1_0_0_1_1, 10'b0001_0010_10}) begin
            miscompares++;
            $display("FAIL game_over: got %b expected %b", {o_en, o_sc},
                     {8'b100_1_0_0_1_1, 10'b0001_0010_10});
        end
        frame();
        miss1 = 1'b1;
        step(1);
        miss1 = 1'b0;
        miss2 = 1'b1;
        step(1);
        miss2 = 1'b0;
        vectors++;
        if ({o_en, o_sc} !== {8'b100_1_0_0_1_0, 10'b0001_0010_10}) begin
            miscompares++;
            $display("FAIL over_blink_miss_ignored: got %b expected %b", {o_en, o_sc},
                     {8'b100_1_0_0_1_0, 10'b0001_0010_10});
        end
        frame();
        vectors++;
        if (o_en !== 8'b100_1_0_0_1_1) begin
            miscompares++;
            $display("FAIL over_blink_back: got %b expected %b", o_en, 8'b100_1_0_0_1_1);
        end
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        vectors++;
        if ({o_en, o_sc} !== {8'b000_1_0_0_1_1, 10'b0001_0010_10}) begin
            miscompares++;
            $display("FAIL over_to_idle_held: got %b expected %b", {o_en, o_sc},
                     {8'b000_1_0_0_1_1, 10'b0001_0010_10});
        end
        step(1);
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        vectors++;
        if ({o_en, o_sc} !== {8'b001_0_1_0_1_1, 10'b0000_0000_00}) begin
            miscompares++;
            $display("FAIL new_game_clear: got %b expected %b", {o_en, o_sc},
                     {8'b001_0_1_0_1_1, 10'b0000_0000_00});
        end
    endtask

    task automatic test_reset_in_point();
        repeat (4) frame();
        miss2 = 1'b1;
        step(1);
        miss2 = 1'b0;
        vectors++;
        if ({o_en, o_sc} !== {8'b011_0_0_0_1_1, 10'b0001_0000_00}) begin
            miscompares++;
            $display("FAIL pre_reset_point: got %b expected %b", {o_en, o_sc},
                     {8'b011_0_0_0_1_1, 10'b0001_0000_00});
        end
        step(3);
        reset      = 1'b1;
        frame_tick = 1'b1;
        miss1      = 1'b1;
        step(1);
        reset      = 1'b0;
        frame_tick = 1'b0;
        miss1      = 1'b0;
        vectors++;
        if ({o_en, o_sc} !== {8'b000_1_0_0_1_1, 10'b0000_0000_00}) begin
            miscompares++;
            $display("FAIL reset_in_point: got %b expected %b", {o_en, o_sc},
                     {8'b000_1_0_0_1_1, 10'b0000_0000_00});
        end
        step(2);
        vectors++;
        if ({o_en, o_sc} !== {8'b000_1_0_0_1_1, 10'b0000_0000_00}) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b expected %b", {o_en, o_sc},
                     {8'b000_1_0_0_1_1, 10'b0000_0000_00});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        frame_tick  = 1'b0;
        start_btn   = 1'b0;
        miss1       = 1'b0;
        miss2       = 1'b0;
        #1;
        test_reset();
        test_serve();
        test_scoring();
        test_double_miss();
        test_game_over();
        test_reset_in_point();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
